// File: rtl/uart_vga_pkg.sv
// Shared constants and types for the UART-to-display-RAM loader.
package uart_vga_pkg;

  localparam int BYTES_PER_ROW = 20;
  localparam int ROWS          = 64;
  localparam int FRAME_BYTES   = BYTES_PER_ROW * ROWS;
  localparam int ADDR_W        = $clog2(FRAME_BYTES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchronizer, mid-bit sampling FSM.
// o_byte_valid / o_frame_err are single-cycle strobes on the stop-bit
// sample cycle; o_byte holds the last shifted byte.
// o_idle_high exists only with UART_VGA_LOADER_RESYNC_EN defined.
module uart_rx_byte
  import uart_vga_pkg::*;
#(
  parameter int CLKS_PER_BIT = 937
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_byte_valid,
`ifdef UART_VGA_LOADER_RESYNC_EN
  output logic       o_idle_high,
`endif
  output logic       o_frame_err
);

  localparam int HALF  = CLKS_PER_BIT / 2;
  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

  logic [1:0]       r_sync;
  rx_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_wait_high, w_wait_nxt;
  logic             w_rx;
  logic             w_valid;
  logic             w_err;

  assign w_rx = r_sync[1];

  // State register, counters and the two-stage rx synchronizer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync      <= 2'b11;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_bit       <= 3'd0;
      r_shift     <= 8'h00;
      r_wait_high <= 1'b0;
    end else begin
      r_sync      <= {r_sync[0], i_rx};
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_wait_high <= w_wait_nxt;
    end
  end

  // Next-state logic: start qualification, LSB-first data shift, stop check.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_wait_nxt  = r_wait_high;
    w_valid     = 1'b0;
    w_err       = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (w_rx) begin
          // Line is high again: a new start bit may be accepted.
          w_wait_nxt = 1'b0;
        end else if (!r_wait_high) begin
          w_state_nxt = START;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      START: begin
        if (r_cnt == CNT_W'(HALF - 1)) begin
          w_cnt_nxt = '0;
          w_bit_nxt = 3'd0;
          if (w_rx) begin
            w_state_nxt = IDLE;   // glitch shorter than half a bit
          end else begin
            w_state_nxt = DATA;
          end
        end else begin
          w_state_nxt = START;
        end
      end
      DATA: begin
        if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            w_state_nxt = STOP;
          end else begin
            w_state_nxt = DATA;
          end
        end else begin
          w_state_nxt = DATA;
        end
      end
      STOP: begin
        if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
          w_cnt_nxt   = '0;
          w_state_nxt = IDLE;
          if (w_rx) begin
            w_valid = 1'b1;
          end else begin
            w_err      = 1'b1;
            w_wait_nxt = 1'b1;
          end
        end else begin
          w_state_nxt = STOP;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_byte       = r_shift;
  assign o_byte_valid = w_valid;
  assign o_frame_err  = w_err;
`ifdef UART_VGA_LOADER_RESYNC_EN
  assign o_idle_high  = (r_state == IDLE) && w_rx;
`endif

endmodule

// File: rtl/uart_vga_loader.sv
// UART loader for the bit-display VGA stage: each received byte is written
// linearly into the display RAM (ROWS x BYTES_PER_ROW bytes), wrapping at
// the end of the frame. Optional feature macro: UART_VGA_LOADER_RESYNC_EN
// (long idle line returns the write address to 0).
module uart_vga_loader #(
  parameter int CLK_HZ            = 108000000,
  parameter int BAUD              = 115200,
  parameter int BYTES_PER_ROW     = uart_vga_pkg::BYTES_PER_ROW,
`ifdef UART_VGA_LOADER_RESYNC_EN
  parameter int IDLE_TIMEOUT_BITS = 20,
`endif
  parameter int ROWS              = uart_vga_pkg::ROWS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rx,
  output logic [31:0] write_address,
  output logic [7:0]  ram_in,
  output logic        we,
  output logic        frame_done,
  output logic        rx_error
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int FRAME_BYTES  = BYTES_PER_ROW * ROWS;
  localparam int ADDR_W       = $clog2(FRAME_BYTES);

  logic [7:0]        w_byte;
  logic              w_valid;
  logic              w_err;
  logic              w_last;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [7:0]        r_ram_in;
  logic              r_we;
  logic              r_frame_done;
  logic              r_rx_error;

`ifdef UART_VGA_LOADER_RESYNC_EN
  localparam int TIMEOUT_CLKS = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int IDLE_W       = $clog2(TIMEOUT_CLKS + 1);
  logic              w_idle_high;
  logic              w_timeout;
  logic [IDLE_W-1:0] r_idle_cnt;
`endif

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk         (clk),
    .rst         (rst),
    .i_rx        (uart_rx),
    .o_byte      (w_byte),
    .o_byte_valid(w_valid),
`ifdef UART_VGA_LOADER_RESYNC_EN
    .o_idle_high (w_idle_high),
`endif
    .o_frame_err (w_err)
  );

  assign w_last = (r_addr == ADDR_W'(FRAME_BYTES - 1));

`ifdef UART_VGA_LOADER_RESYNC_EN
  assign w_timeout = (r_idle_cnt == IDLE_W'(TIMEOUT_CLKS));

  // Idle-line timer: counts high idle time, saturates at the timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idle_cnt <= '0;
    end else if (w_valid || !w_idle_high) begin
      r_idle_cnt <= '0;
    end else if (!w_timeout) begin
      r_idle_cnt <= r_idle_cnt + IDLE_W'(1);
    end
  end
`endif

  // Next write address: advance with each write, wrap at frame end.
  always_comb begin
    w_addr_nxt = r_addr;
    if (w_valid) begin
      w_addr_nxt = w_last ? '0 : r_addr + ADDR_W'(1);
`ifdef UART_VGA_LOADER_RESYNC_EN
    end else if (w_timeout && (r_addr != '0)) begin
      w_addr_nxt = '0;
`endif
    end else begin
      w_addr_nxt = r_addr;
    end
  end

  // Registered write port and status strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr       <= '0;
      r_wr_addr    <= '0;
      r_ram_in     <= 8'h00;
      r_we         <= 1'b0;
      r_frame_done <= 1'b0;
      r_rx_error   <= 1'b0;
    end else begin
      r_addr       <= w_addr_nxt;
      r_we         <= w_valid;
      r_frame_done <= w_valid && w_last;
      r_rx_error   <= w_err;
      if (w_valid) begin
        r_wr_addr <= r_addr;
        r_ram_in  <= w_byte;
      end
    end
  end

  assign write_address = 32'(r_wr_addr);
  assign ram_in        = r_ram_in;
  assign we            = r_we;
  assign frame_done    = r_frame_done;
  assign rx_error      = r_rx_error;

endmodule

// File: tb/tb_uart_vga_loader.sv
// Scoreboard bench for uart_vga_loader at 16 clocks per bit. The frame is
// shortened to 8 rows (160 bytes) so the wrap/frame_done path is reached
// within a short run; the wrap logic is size-independent.
module tb_uart_vga_loader;

  localparam int CLK_HZ = 16;
  localparam int BAUD   = 1;
  localparam int CPB    = CLK_HZ / BAUD;
  localparam int BPR    = 20;
  localparam int ROWS   = 8;
  localparam int FRAME  = BPR * ROWS;

  typedef struct {
    int         addr;
    logic [7:0] data;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_rx = 1'b1;
  logic [31:0] write_address;
  logic [7:0]  ram_in;
  logic        we;
  logic        frame_done;
  logic        rx_error;

  exp_t exp_q[$];
  int   err_pending = 0;
  int   fd_count = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  uart_vga_loader #(
    .CLK_HZ       (CLK_HZ),
    .BAUD         (BAUD),
    .BYTES_PER_ROW(BPR),
    .ROWS         (ROWS)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rx      (uart_rx),
    .write_address(write_address),
    .ram_in       (ram_in),
    .we           (we),
    .frame_done   (frame_done),
    .rx_error     (rx_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_write(input int addr, input logic [7:0] data, input logic fd);
    exp_t e;
    e.addr = addr;
    e.data = data;
    e.fd   = fd;
    exp_q.push_back(e);
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends one 8N1 frame; rst_bit >= 0 pulses rst in the middle of that data bit.
  task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int rst_bit);
    uart_rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      if (i == rst_bit) begin
        wait_clks(CPB / 2);
        rst = 1'b1;
        wait_clks(2);
        rst = 1'b0;
        wait_clks(CPB - CPB / 2 - 2);
      end else begin
        wait_clks(CPB);
      end
    end
    uart_rx = stop_bit;
    wait_clks(CPB);
    uart_rx = 1'b1;
    wait_clks(2 * CPB);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(3);
  endtask

  // Monitor: pops the scoreboard on each write and accounts for error pulses.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (we) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_we: addr=%0d data=0x%0h, expected no write", write_address, ram_in);
      end else begin
        e = exp_q.pop_front();
        check("write_address", write_address, 32'(e.addr));
        check("ram_in", {24'h0, ram_in}, {24'h0, e.data});
        check("frame_done", {31'h0, frame_done}, {31'h0, e.fd});
      end
    end else if (frame_done) begin
      n_tests++;
      n_fail++;
      $display("FAIL frame_done_no_we: got frame_done=1 without we, expected 0");
    end
    if (frame_done) fd_count++;
    if (rx_error) begin
      n_tests++;
      if (err_pending > 0) begin
        err_pending--;
      end else begin
        n_fail++;
        $display("FAIL unexpected_rx_error: got rx_error=1, expected 0");
      end
    end
  end

  initial begin
    wait_clks(4);
    check("rst_write_address", write_address, 32'h0);
    check("rst_ram_in", {24'h0, ram_in}, 32'h0);
    check("rst_we", {31'h0, we}, 32'h0);
    check("rst_frame_done", {31'h0, frame_done}, 32'h0);
    check("rst_rx_error", {31'h0, rx_error}, 32'h0);
    rst = 1'b0;
    wait_clks(4);

    // Basic writes at consecutive addresses.
    expect_write(0, 8'hA5, 1'b0);
    send_byte(8'hA5, 1'b1, -1);
    expect_write(1, 8'h3C, 1'b0);
    send_byte(8'h3C, 1'b1, -1);

    // Full frame from address 0, frame_done only on the last byte, then wrap.
    pulse_rst();
    fd_count = 0;
    for (int a = 0; a < FRAME; a++) begin
      expect_write(a, 8'(a), (a == FRAME - 1));
      send_byte(8'(a), 1'b1, -1);
    end
    check("frame_done_count", 32'(fd_count), 32'd1);
    expect_write(0, 8'h77, 1'b0);
    send_byte(8'h77, 1'b1, -1);
    check("frame_done_count_after_wrap", 32'(fd_count), 32'd1);

    // Framing error: no write, address held; next good byte at same address.
    err_pending++;
    send_byte(8'h55, 1'b0, -1);
    check("rx_error_seen", 32'(err_pending), 32'd0);
    expect_write(1, 8'h81, 1'b0);
    send_byte(8'h81, 1'b1, -1);

    // Short low glitch on the idle line: nothing happens, receiver recovers.
    uart_rx = 1'b0;
    wait_clks(4);
    uart_rx = 1'b1;
    wait_clks(3 * CPB);
    expect_write(2, 8'h42, 1'b0);
    send_byte(8'h42, 1'b1, -1);

    // Reset in the middle of data bit 4: partial byte lost, outputs cleared.
    send_byte(8'hF3, 1'b1, 4);
    check("midrst_write_address", write_address, 32'h0);
    check("midrst_ram_in", {24'h0, ram_in}, 32'h0);
    check("midrst_we", {31'h0, we}, 32'h0);
    expect_write(0, 8'h01, 1'b0);
    send_byte(8'h01, 1'b1, -1);

    // Long idle after five bytes: address resync only with the feature enabled.
    pulse_rst();
    for (int k = 0; k < 5; k++) begin
      expect_write(k, 8'h10 + 8'(k), 1'b0);
      send_byte(8'h10 + 8'(k), 1'b1, -1);
    end
    wait_clks(20 * CPB + 1);
`ifdef UART_VGA_LOADER_RESYNC_EN
    expect_write(0, 8'hFF, 1'b0);
`else
    expect_write(5, 8'hFF, 1'b0);
`endif
    send_byte(8'hFF, 1'b1, -1);

    wait_clks(40);
    check("pending_writes", 32'(exp_q.size()), 32'd0);
    check("pending_errors", 32'(err_pending), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
